// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the sequencing control unit (slave) and the
// fetch/decode + datapath side (master).
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 8,
  parameter int ALUOP_W  = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_busywait;
  logic                writeable;
  logic [ALUOP_W-1:0]  aluop;
  logic                mux1op;
  logic                mux2op;
  logic [1:0]          bselect;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                pc_stall;
  logic                illegal;

  modport master (
    output opcode, mem_busywait,
    input  writeable, aluop, mux1op, mux2op, bselect,
    input  mem_read, mem_write, mem_to_reg, pc_stall, illegal
  );

  modport slave (
    input  opcode, mem_busywait,
    output writeable, aluop, mux1op, mux2op, bselect,
    output mem_read, mem_write, mem_to_reg, pc_stall, illegal
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Opcode decoder and stall sequencer for the simple CPU: single-cycle ops
// decode combinationally, mult and data-memory accesses hold the PC.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 8,
  parameter int ALUOP_W     = 3,
  parameter int MULT_CYCLES = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  multicycle_control_unit_if.slave    bus
);

  localparam int CNT_W = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES - 1) : 1;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MULT_WAIT = 2'd1,
    MEM_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic       writeable;
    logic [2:0] aluop;
    logic       mux1op;
    logic       mux2op;
    logic [1:0] bselect;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
    logic       is_mult;
  } ctl_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [OPCODE_W-1:0] opcode_q, opcode_q_next;
  ctl_t                ctl;

  logic               writeable;
  logic [ALUOP_W-1:0] aluop;
  logic               mux1op;
  logic               mux2op;
  logic [1:0]         bselect;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               pc_stall;
  logic               illegal;

  // Any set bit above bit 7 makes the opcode illegal regardless of the low byte.
  function automatic ctl_t decode(input logic [OPCODE_W-1:0] op);
    ctl_t c;
    c = '0;
    if ((op >> 8) != '0) begin
      c.illegal = 1'b1;
    end else begin
      case (8'(op))
        8'd0:  begin c.mux2op = 1'b1; c.writeable = 1'b1; end
        8'd1:  c.writeable = 1'b1;
        8'd2:  begin c.aluop = 3'b001; c.writeable = 1'b1; end
        8'd3:  begin c.aluop = 3'b010; c.mux1op = 1'b1; c.writeable = 1'b1; end
        8'd4:  begin c.aluop = 3'b011; c.writeable = 1'b1; end
        8'd5:  begin c.aluop = 3'b100; c.writeable = 1'b1; end
        8'd6:  c.bselect = 2'b01;
        8'd7:  begin c.aluop = 3'b001; c.mux1op = 1'b1; c.bselect = 2'b10; end
        8'd8:  begin c.aluop = 3'b001; c.mux1op = 1'b1; c.bselect = 2'b11; end
        8'd9:  begin
          c.aluop     = 3'b110;
          c.is_mult   = 1'b1;
          c.writeable = (MULT_CYCLES == 1);
        end
        8'd10: c.mem_read = 1'b1;
        8'd11: begin c.mem_read = 1'b1; c.mux2op = 1'b1; end
        8'd12: c.mem_write = 1'b1;
        8'd13: begin c.mem_write = 1'b1; c.mux2op = 1'b1; end
        default: c.illegal = 1'b1;
      endcase
    end
    return c;
  endfunction

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= RUN;
      cnt      <= '0;
      opcode_q <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      opcode_q <= opcode_q_next;
    end
  end

  // Wait states decode the latched opcode so fetch may move the live opcode freely.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    opcode_q_next = opcode_q;
    writeable     = 1'b0;
    aluop         = '0;
    mux1op        = 1'b0;
    mux2op        = 1'b0;
    bselect       = 2'b00;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    pc_stall      = 1'b0;
    illegal       = 1'b0;
    ctl           = decode((state == RUN) ? bus.opcode : opcode_q);

    case (state)
      RUN: begin
        writeable = ctl.writeable;
        aluop     = ALUOP_W'(ctl.aluop);
        mux1op    = ctl.mux1op;
        mux2op    = ctl.mux2op;
        bselect   = ctl.bselect;
        mem_read  = ctl.mem_read;
        mem_write = ctl.mem_write;
        illegal   = ctl.illegal;
        if (ctl.is_mult && (MULT_CYCLES > 1)) begin
          writeable     = 1'b0;
          pc_stall      = 1'b1;
          cnt_next      = CNT_W'(MULT_CYCLES - 2);
          opcode_q_next = bus.opcode;
          state_next    = MULT_WAIT;
        end else if (ctl.mem_read || ctl.mem_write) begin
          pc_stall      = 1'b1;
          opcode_q_next = bus.opcode;
          state_next    = MEM_WAIT;
        end
      end
      MULT_WAIT: begin
        aluop = ALUOP_W'(3'b110);
        if (cnt != '0) begin
          pc_stall = 1'b1;
          cnt_next = cnt - 1'b1;
        end else begin
          writeable  = 1'b1;
          state_next = RUN;
        end
      end
      MEM_WAIT: begin
        aluop     = ALUOP_W'(ctl.aluop);
        mux2op    = ctl.mux2op;
        mem_read  = ctl.mem_read;
        mem_write = ctl.mem_write;
        if (bus.mem_busywait) begin
          pc_stall = 1'b1;
        end else begin
          writeable  = ctl.mem_read;
          mem_to_reg = ctl.mem_read;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase

    // Outputs follow reset immediately so an aborted access drops its request at once.
    if (!RESET) begin
      writeable  = 1'b0;
      aluop      = '0;
      mux1op     = 1'b0;
      mux2op     = 1'b0;
      bselect    = 2'b00;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      pc_stall   = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign bus.writeable  = writeable;
  assign bus.aluop      = aluop;
  assign bus.mux1op     = mux1op;
  assign bus.mux2op     = mux2op;
  assign bus.bselect    = bselect;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.pc_stall   = pc_stall;
  assign bus.illegal    = illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: the driver queues hand-computed control vectors per cycle,
// a negedge monitor pops and compares them against two DUT configurations.
module tb_multicycle_control_unit;

  logic CLK;
  logic RESET;

  multicycle_control_unit_if #(.OPCODE_W(8), .ALUOP_W(3)) b0 ();
  multicycle_control_unit_if #(.OPCODE_W(8), .ALUOP_W(3)) b1 ();

  multicycle_control_unit #(.OPCODE_W(8), .ALUOP_W(3), .MULT_CYCLES(4)) dut0 (
    .CLK(CLK), .RESET(RESET), .bus(b0)
  );
  multicycle_control_unit #(.OPCODE_W(8), .ALUOP_W(3), .MULT_CYCLES(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .bus(b1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [12:0] v;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // {writeable, aluop, mux1op, mux2op, bselect, mem_read, mem_write, mem_to_reg, pc_stall, illegal}
  function automatic logic [12:0] ev(input logic w, input logic [2:0] alu, input logic m1,
                                     input logic m2, input logic [1:0] bs, input logic mr,
                                     input logic mw, input logic m2r, input logic ps,
                                     input logic ill);
    return {w, alu, m1, m2, bs, mr, mw, m2r, ps, ill};
  endfunction

  function automatic logic [12:0] act0();
    return {b0.writeable, b0.aluop, b0.mux1op, b0.mux2op, b0.bselect, b0.mem_read,
            b0.mem_write, b0.mem_to_reg, b0.pc_stall, b0.illegal};
  endfunction

  function automatic logic [12:0] act1();
    return {b1.writeable, b1.aluop, b1.mux1op, b1.mux2op, b1.bselect, b1.mem_read,
            b1.mem_write, b1.mem_to_reg, b1.pc_stall, b1.illegal};
  endfunction

  task automatic cyc(input int d, input logic [7:0] op, input logic busy, input logic rst,
                     input logic [12:0] v, input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    RESET = rst;
    e.v    = v;
    e.name = nm;
    if (d == 0) begin
      b0.opcode       = op;
      b0.mem_busywait = busy;
      q0.push_back(e);
    end else begin
      b1.opcode       = op;
      b1.mem_busywait = busy;
      q1.push_back(e);
    end
  endtask

  always @(negedge CLK) begin
    exp_t        e;
    logic [12:0] a;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = act0();
      n_cmp++;
      if (a !== e.v) begin
        n_bad++;
        $display("FAIL %s (mc4): got %013b want %013b", e.name, a, e.v);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = act1();
      n_cmp++;
      if (a !== e.v) begin
        n_bad++;
        $display("FAIL %s (mc1): got %013b want %013b", e.name, a, e.v);
      end
    end
  end

  initial begin
    RESET           = 1'b0;
    b0.opcode       = 8'd0;
    b0.mem_busywait = 1'b0;
    b1.opcode       = 8'd2;
    b1.mem_busywait = 1'b0;

    cyc(0, 8'd2, 0, 0, ev(0, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0, 0), "reset_held");

    // single-cycle decode
    cyc(0, 8'd2, 0, 1, ev(1, 3'b001, 0, 0, 2'b00, 0, 0, 0, 0, 0), "add");
    cyc(0, 8'd3, 0, 1, ev(1, 3'b010, 1, 0, 2'b00, 0, 0, 0, 0, 0), "sub");
    cyc(0, 8'd7, 0, 1, ev(0, 3'b001, 1, 0, 2'b10, 0, 0, 0, 0, 0), "beq");
    cyc(0, 8'd6, 0, 1, ev(0, 3'b000, 0, 0, 2'b01, 0, 0, 0, 0, 0), "j");
    cyc(0, 8'd8, 0, 1, ev(0, 3'b001, 1, 0, 2'b11, 0, 0, 0, 0, 0), "bne");
    cyc(0, 8'd0, 0, 1, ev(1, 3'b000, 0, 1, 2'b00, 0, 0, 0, 0, 0), "loadi");

    // 4-cycle mult, live opcode changes mid-wait
    cyc(0, 8'd9, 1, 1, ev(0, 3'b110, 0, 0, 2'b00, 0, 0, 0, 1, 0), "mult_c0");
    cyc(0, 8'd2, 1, 1, ev(0, 3'b110, 0, 0, 2'b00, 0, 0, 0, 1, 0), "mult_c1");
    cyc(0, 8'd2, 0, 1, ev(0, 3'b110, 0, 0, 2'b00, 0, 0, 0, 1, 0), "mult_c2");
    cyc(0, 8'd2, 0, 1, ev(1, 3'b110, 0, 0, 2'b00, 0, 0, 0, 0, 0), "mult_c3");
    cyc(0, 8'd4, 0, 1, ev(1, 3'b011, 0, 0, 2'b00, 0, 0, 0, 0, 0), "and_after_mult");

    // load with three busy cycles in MEM_WAIT
    cyc(0, 8'd10, 1, 1, ev(0, 3'b000, 0, 0, 2'b00, 1, 0, 0, 1, 0), "lwd_c0");
    cyc(0, 8'd2,  1, 1, ev(0, 3'b000, 0, 0, 2'b00, 1, 0, 0, 1, 0), "lwd_c1");
    cyc(0, 8'd2,  1, 1, ev(0, 3'b000, 0, 0, 2'b00, 1, 0, 0, 1, 0), "lwd_c2");
    cyc(0, 8'd2,  1, 1, ev(0, 3'b000, 0, 0, 2'b00, 1, 0, 0, 1, 0), "lwd_c3");
    cyc(0, 8'd2,  0, 1, ev(1, 3'b000, 0, 0, 2'b00, 1, 0, 1, 0, 0), "lwd_c4");

    // store completes at once; next op back-to-back
    cyc(0, 8'd13, 0, 1, ev(0, 3'b000, 0, 1, 2'b00, 0, 1, 0, 1, 0), "swi_c0");
    cyc(0, 8'd3,  0, 1, ev(0, 3'b000, 0, 1, 2'b00, 0, 1, 0, 0, 0), "swi_c1");
    cyc(0, 8'd1,  0, 1, ev(1, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0, 0), "mov_after_swi");

    // illegal opcodes
    cyc(0, 8'hFF, 1, 1, ev(0, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0, 1), "illegal_ff");
    cyc(0, 8'd14, 0, 1, ev(0, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0, 1), "illegal_14");
    cyc(0, 8'd5,  0, 1, ev(1, 3'b100, 0, 0, 2'b00, 0, 0, 0, 0, 0), "or_after_ill");

    // reset during MEM_WAIT aborts the access
    cyc(0, 8'd10, 1, 1, ev(0, 3'b000, 0, 0, 2'b00, 1, 0, 0, 1, 0), "lwd_abort_c0");
    cyc(0, 8'd2,  1, 1, ev(0, 3'b000, 0, 0, 2'b00, 1, 0, 0, 1, 0), "lwd_abort_c1");
    cyc(0, 8'd2,  1, 0, ev(0, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0, 0), "reset_mid_mem");
    cyc(0, 8'd0,  1, 1, ev(1, 3'b000, 0, 1, 2'b00, 0, 0, 0, 0, 0), "loadi_after_rst");

    // single-cycle mult configuration
    cyc(1, 8'd9, 0, 1, ev(1, 3'b110, 0, 0, 2'b00, 0, 0, 0, 0, 0), "mult_1cyc");
    cyc(1, 8'd2, 0, 1, ev(1, 3'b001, 0, 0, 2'b00, 0, 0, 0, 0, 0), "add_after_mult1");

    repeat (3) @(posedge CLK);
    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
